uart_tx_frame: RTL and testbench

// - Parametrised RS-232 serial transmitter: accepts a parallel word over a valid/ready handshake and

---
 rtl/uart_tx_frame.sv | 153 +++++++++++++++
 tb/tb_uart_tx_frame.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// Framed LSB-first serial transmitter with a valid/ready input and fixed baud divider.
// Define UART_TX_PARITY_EN to add the parity_odd input and a parity bit after the data bits.
module uart_tx_frame #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 data_valid,
`ifdef UART_TX_PARITY_EN
  input  logic                 parity_odd,
`endif
  output logic                 data_ready,
  output logic                 op_bit,
  output logic                 idle,
  output logic                 start,
  output logic                 stop
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DB_LAST  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] SB_LAST  = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q;
  logic [BW-1:0]        baud_q;
  logic [IW-1:0]        idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 op_q;
  logic                 idle_q;
  logic                 rdy_q;
  logic                 start_q;
  logic                 stop_q;
`ifdef UART_TX_PARITY_EN
  logic                 par_q;
`endif

  logic baud_end;
  assign baud_end = (baud_q == BAUD_MAX);

  // idx_q counts data bits in DATA and stop bits in STOP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      op_q    <= 1'b1;
      idle_q  <= 1'b1;
      rdy_q   <= 1'b1;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (data_valid) begin
            shift_q <= data;
`ifdef UART_TX_PARITY_EN
            par_q   <= (^data) ^ parity_odd;
`endif
            state_q <= S_START;
            baud_q  <= '0;
            idx_q   <= '0;
            op_q    <= 1'b0;
            start_q <= 1'b1;
            idle_q  <= 1'b0;
            rdy_q   <= 1'b0;
          end
        end
        S_START: begin
          if (baud_end) begin
            baud_q  <= '0;
            state_q <= S_DATA;
            start_q <= 1'b0;
            op_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (idx_q == DB_LAST) begin
              idx_q   <= '0;
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
              op_q    <= par_q;
`else
              state_q <= S_STOP;
              op_q    <= 1'b1;
              stop_q  <= 1'b1;
`endif
            end else begin
              idx_q   <= idx_q + 1'b1;
              shift_q <= shift_q >> 1;
              op_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (baud_end) begin
            baud_q  <= '0;
            state_q <= S_STOP;
            op_q    <= 1'b1;
            stop_q  <= 1'b1;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_end) begin
            baud_q <= '0;
            if (idx_q == SB_LAST) begin
              idx_q   <= '0;
              state_q <= S_IDLE;
              stop_q  <= 1'b0;
              idle_q  <= 1'b1;
              rdy_q   <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign op_bit     = op_q;
  assign idle       = idle_q;
  assign data_ready = rdy_q;
  assign start      = start_q;
  assign stop       = stop_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: driver pushes hand-built line patterns,
// a monitor decodes each frame cycle by cycle. Honours UART_TX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_tx_frame;

  localparam int C = 4;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [10:0] P_A5 = 11'b10101001010;
  localparam logic [10:0] P_00 = 11'b10000000000;
  localparam logic [10:0] P_FF = 11'b10111111110;
  localparam logic [10:0] P_5A = 11'b10010110100;
  localparam logic [10:0] P_3C = 11'b10001111000;
`else
  localparam int NB = 10;
  localparam logic [10:0] P_A5 = 11'b01101001010;
  localparam logic [10:0] P_00 = 11'b01000000000;
  localparam logic [10:0] P_FF = 11'b01111111110;
  localparam logic [10:0] P_5A = 11'b01010110100;
  localparam logic [10:0] P_3C = 11'b01001111000;
`endif

  typedef struct {
    logic [10:0] pat;
    int          gap;
  } exp_t;

  logic clk, rst;
  logic [7:0] data_a;
  logic valid_a, par_odd_a;
  logic data_ready_a, op_a, idle_a, start_a, stop_a;
  logic [7:0] data_b;
  logic valid_b;
  logic ready_b, op_b, idle_b, start_b, stop_b;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(C), .STOP_BITS(1)) dut (
    .clk(clk),
    .rst(rst),
    .data(data_a),
    .data_valid(valid_a),
`ifdef UART_TX_PARITY_EN
    .parity_odd(par_odd_a),
`endif
    .data_ready(data_ready_a),
    .op_bit(op_a),
    .idle(idle_a),
    .start(start_a),
    .stop(stop_a)
  );

  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(16), .STOP_BITS(2)) dut_b (
    .clk(clk),
    .rst(rst),
    .data(data_b),
    .data_valid(valid_b),
`ifdef UART_TX_PARITY_EN
    .parity_odd(1'b0),
`endif
    .data_ready(ready_b),
    .op_bit(op_b),
    .idle(idle_b),
    .start(start_b),
    .stop(stop_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: one comparison per serial bit plus gap and post-frame checks
  initial begin : mon
    int   idle_run;
    exp_t e;
    bit   abort;
    logic [4:0] act, req, bad;
    idle_run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        idle_run = 0;
        continue;
      end
      if (!start_a) begin
        if (idle_a) idle_run++;
        else idle_run = 0;
        continue;
      end
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame actual=1 required=0");
        while (start_a && !rst) @(negedge clk);
        continue;
      end
      e = q.pop_front();
      if (e.gap >= 0) chk("gap", idle_run, e.gap);
      abort = 0;
      for (int k = 0; k < NB; k++) begin
        req = {e.pat[k], k == 0, k == NB - 1, 2'b00};
        bad = req;
        for (int c = 0; c < C; c++) begin
          if (k != 0 || c != 0) @(negedge clk);
          if (rst) begin
            abort = 1;
            break;
          end
          act = {op_a, start_a, stop_a, idle_a, data_ready_a};
          if (act !== req && bad === req) bad = act;
        end
        if (abort) break;
        chk($sformatf("bit%0d", k), bad, req);
      end
      if (abort) begin
        idle_run = 0;
        continue;
      end
      @(negedge clk);
      chk("post_idle", {idle_a, data_ready_a, op_a, stop_a}, 4'b1110);
      idle_run = idle_a ? 1 : 0;
    end
  end

  task automatic send(input logic [7:0] d, input logic [10:0] pat,
                      input int gap, input bit hold, input bit po);
    int n;
    exp_t e;
    @(negedge clk);
    data_a    = d;
    par_odd_a = po;
    valid_a   = 1'b1;
    n = 0;
    while (!data_ready_a && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=0 required=1");
    end
    e.pat = pat;
    e.gap = gap;
    q.push_back(e);
    @(negedge clk);
    if (!hold) valid_a = 1'b0;
    data_a    = ~d;
    par_odd_a = ~po;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((q.size() != 0 || !idle_a) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=%0d required=0", q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    rst = 1'b1;
    valid_a = 1'b0;
    data_a = 8'h00;
    par_odd_a = 1'b0;
    valid_b = 1'b0;
    data_b = 8'h00;
    #1;
    chk("reset_a", {op_a, idle_a, data_ready_a, start_a, stop_a}, 5'b11100);
    repeat (3) @(negedge clk);
    chk("reset_b", {op_b, idle_b, ready_b, start_b, stop_b}, 5'b11100);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    send(8'hA5, P_A5, -1, 1'b0, 1'b0);
    wait_done();

    send(8'h00, P_00, -1, 1'b1, 1'b0);
    send(8'hFF, P_FF, 1, 1'b0, 1'b0);
    wait_done();

    send(8'h5A, P_5A, -1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    data_a  = 8'h11;
    valid_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("busy_ready", data_ready_a, 1'b0);
    valid_a = 1'b0;
    wait_done();
    repeat (60) @(negedge clk);

    send(8'h3C, P_3C, -1, 1'b0, 1'b0);
    n = 0;
    while (!start_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("start_seen", start_a, 1'b1);
    repeat (4 + 3 * C + 2) @(negedge clk);
    chk("in_data", {idle_a, start_a, stop_a}, 3'b000);
    #1 rst = 1'b1;
    #1;
    chk("rst_async", {op_a, idle_a, data_ready_a, start_a, stop_a}, 5'b11100);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send(8'h3C, P_3C, -1, 1'b0, 1'b0);
    wait_done();

`ifdef UART_TX_PARITY_EN
    send(8'h07, 11'b11000001110, -1, 1'b0, 1'b0);
    wait_done();
    send(8'h07, 11'b10000001110, -1, 1'b0, 1'b1);
    wait_done();
`endif

    @(negedge clk);
    data_b  = 8'h81;
    valid_b = 1'b1;
    @(negedge clk);
    valid_b = 1'b0;
    chk("b_busy", {idle_b, ready_b, start_b, op_b}, 4'b0010);
    n = 0;
    while (!stop_b && n < 400) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (stop_b && op_b && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b_stop_len", n, 32);
    chk("b_after", {idle_b, ready_b, op_b, stop_b, start_b}, 5'b11100);

    repeat (20) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
